// File: rtl/uart_cmd_host_pkg.sv
// Shared types and constants for the UART command host.
//   host_state_e : host FSM state encoding
//   CMD_GO       : command byte that starts the Segway
//   CMD_STOP     : command byte that stops the Segway (sent on abort)
package uart_cmd_host_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StGap,
        StAbortIssue,
        StAbortWait
    } host_state_e;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/uart_cmd_host_if.sv
// Bundle between a command source and the command host, plus the UART_tx handshake.
//   master : control side (en, loop_mode, gap_cycles, push/push_data, abort) and tx_done
//   slave  : the host (trmt, tx_data, full, empty, ovf, busy, sent_cnt)
interface uart_cmd_host_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned CNT_W  = 8
);
    logic              en;
    logic              loop_mode;
    logic [GAP_W-1:0]  gap_cycles;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              abort;
    logic              tx_done;
    logic              trmt;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              busy;
    logic [CNT_W-1:0]  sent_cnt;

    modport master (
        output en, loop_mode, gap_cycles, push, push_data, abort, tx_done,
        input  trmt, tx_data, full, empty, ovf, busy, sent_cnt
    );

    modport slave (
        input  en, loop_mode, gap_cycles, push, push_data, abort, tx_done,
        output trmt, tx_data, full, empty, ovf, busy, sent_cnt
    );
endinterface

// File: rtl/uart_cmd_host_cmd_fifo.sv
// Command FIFO: circular buffer of DEPTH entries (power of 2) with an occupancy count.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : synchronous clear of pointers and count
//   push, wdata  : write request and data (accepted when not full, or when popping too)
//   pop, rdata   : read request; rdata shows the head entry combinationally
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module uart_cmd_host_cmd_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is allowed then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_cmd_host.sv
// Command host: queues command bytes and streams them to a UART transmitter with a
// programmable idle gap after each completion, an optional replay loop and a priority
// abort that flushes the queue and sends ABORT_CMD.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of uart_cmd_host_if
//                inputs  en, loop_mode, gap_cycles, push, push_data, abort, tx_done
//                outputs trmt, tx_data, full, empty, ovf, busy, sent_cnt
module uart_cmd_host
    import uart_cmd_host_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       GAP_W     = 16,
    parameter int unsigned       CNT_W     = 8,
    parameter logic [DATA_W-1:0] ABORT_CMD = DATA_W'(CMD_STOP)
) (
    input logic           clk,
    input logic           rst_n,
    uart_cmd_host_if.slave bus
);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    host_state_e       state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              abort_q, abort_d;
    logic              ovf_q, ovf_d;

    logic              abort_pend, pop, flush, loop_push, ext_push, fifo_push;
    logic [DATA_W-1:0] fifo_wdata, fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    // A pulse arriving this cycle acts immediately; the latch keeps it until ABORT_CMD completes.
    assign abort_pend = abort_q || bus.abort;
    assign flush      = (state_q == StIdle) && abort_pend;
    assign pop        = (state_q == StIdle) && !abort_pend && bus.en && (fifo_count != '0);
    // In loop mode the popped byte takes the write port, so an external push loses.
    assign loop_push  = pop && bus.loop_mode;
    assign ext_push   = bus.push && !fifo_full && !loop_push && !flush;
    assign fifo_push  = loop_push || ext_push;
    assign fifo_wdata = loop_push ? fifo_rdata : bus.push_data;
    assign ovf_d      = bus.push && !ext_push;

    uart_cmd_host_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (abort_pend) state_d = StAbortIssue;
                else if (pop)   state_d = StIssue;
            end
            StIssue:    state_d = StWaitDone;
            StWaitDone: begin
                if (bus.tx_done) begin
                    state_d = (abort_pend || bus.gap_cycles == '0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (abort_pend || gap_q == GAP_W'(1)) state_d = StIdle;
            end
            StAbortIssue: state_d = StAbortWait;
            StAbortWait: begin
                if (bus.tx_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.trmt = (state_q == StIssue) || (state_q == StAbortIssue);
        bus.busy = (state_q != StIdle);
    end

    always_comb begin
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        abort_d   = abort_q || bus.abort;
        case (state_q)
            StIdle: begin
                if (abort_pend) tx_data_d = ABORT_CMD;
                else if (pop)   tx_data_d = fifo_rdata;
            end
            StWaitDone: begin
                if (bus.tx_done) begin
                    sent_d = sent_q + CNT_W'(1);
                    gap_d  = bus.gap_cycles;
                end
            end
            StGap: gap_d = gap_q - GAP_W'(1);
            StAbortWait: begin
                // Clearing wins over a fresh pulse here so repeated aborts yield one stop byte.
                if (bus.tx_done) begin
                    sent_d  = sent_q + CNT_W'(1);
                    abort_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            gap_q     <= '0;
            sent_q    <= '0;
            abort_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            abort_q   <= abort_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.ovf      = ovf_q;
    assign bus.sent_cnt = sent_q;
endmodule

// File: tb/tb_uart_cmd_host.sv
`timescale 1ns/1ps
module tb_uart_cmd_host;
    import uart_cmd_host_pkg::*;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned GAP_W    = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned UART_LAT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_host_if #(.DATA_W(DATA_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

    uart_cmd_host #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .GAP_W     (GAP_W),
        .CNT_W     (CNT_W),
        .ABORT_CMD (CMD_STOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: logs every trmt and answers with a tx_done pulse UART_LAT+1 cycles later.
    logic [DATA_W-1:0] trmt_log [$];
    int unsigned       trmt_cyc [$];
    int unsigned       done_cyc [$];
    bit                uart_busy  = 1'b0;
    int unsigned       uart_timer = 0;

    always @(negedge clk) begin
        bus.tx_done = 1'b0;
        if (uart_busy) begin
            if (uart_timer == 0) begin
                bus.tx_done = 1'b1;
                uart_busy   = 1'b0;
                done_cyc.push_back(cyc);
            end else begin
                uart_timer = uart_timer - 1;
            end
        end
        if (bus.trmt) begin
            trmt_log.push_back(bus.tx_data);
            trmt_cyc.push_back(cyc);
            uart_busy  = 1'b1;
            uart_timer = UART_LAT;
        end
    end

    typedef struct {
        logic       push;
        logic [7:0] data;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] exp_loop [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " trmt"},     32'(bus.trmt),     32'd0);
        check({tag, " tx_data"},  32'(bus.tx_data),  32'd0);
        check({tag, " full"},     32'(bus.full),     32'd0);
        check({tag, " empty"},    32'(bus.empty),    32'd1);
        check({tag, " ovf"},      32'(bus.ovf),      32'd0);
        check({tag, " busy"},     32'(bus.busy),     32'd0);
        check({tag, " sent_cnt"}, 32'(bus.sent_cnt), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.push  = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        bus.push      = 1'b1;
        bus.push_data = d;
        @(negedge clk);
        bus.push = 1'b0;
    endtask

    task automatic clear_logs();
        trmt_log.delete();
        trmt_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_idle(input int unsigned budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && bus.empty && !uart_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " reached idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_log(input int unsigned n, input int unsigned budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (trmt_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " trmt seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_tx_done(input int unsigned budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " tx_done seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ab_cyc;
        int unsigned lat;
        bit          stopped;

        // FIFO fill: 8 accepted, 9th dropped with one ovf pulse, then a quiet cycle.
        vecs[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h17, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h18, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        exp_loop = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01};

        bus.en         = 1'b0;
        bus.loop_mode  = 1'b0;
        bus.gap_cycles = '0;
        bus.push       = 1'b0;
        bus.push_data  = '0;
        bus.abort      = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single command: trmt two cycles after the push edge.
        bus.en = 1'b1;
        clear_logs();
        push_byte(CMD_GO);
        check("single trmt before latency", 32'(bus.trmt), 32'd0);
        @(negedge clk);
        check("single trmt", 32'(bus.trmt), 32'd1);
        check("single tx_data", 32'(bus.tx_data), 32'(CMD_GO));
        @(negedge clk);
        check("single trmt one cycle", 32'(bus.trmt), 32'd0);
        wait_idle(50, "single");
        check("single sent_cnt", 32'(bus.sent_cnt), 32'd1);
        check("single busy", 32'(bus.busy), 32'd0);
        check("single empty", 32'(bus.empty), 32'd1);

        // Overflow table, en low so nothing drains.
        bus.en = 1'b0;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            bus.push      = vecs[i].push;
            bus.push_data = vecs[i].data;
            @(negedge clk);
            check($sformatf("fill[%0d] full", i),  32'(bus.full),  32'(vecs[i].full));
            check($sformatf("fill[%0d] empty", i), 32'(bus.empty), 32'(vecs[i].empty));
            check($sformatf("fill[%0d] ovf", i),   32'(bus.ovf),   32'(vecs[i].ovf));
        end
        bus.push = 1'b0;
        bus.en   = 1'b1;
        wait_idle(400, "drain");
        check("drain count", 32'(trmt_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < trmt_log.size())
                check($sformatf("drain byte[%0d]", i), 32'(trmt_log[i]), 32'(vecs[i].data));
        end
        check("drain sent_cnt", 32'(bus.sent_cnt), 32'd9);

        // Gap of 100: first tx_done to second trmt is 102 clocks.
        bus.en         = 1'b0;
        bus.gap_cycles = 16'd100;
        push_byte(8'h21);
        push_byte(8'h22);
        clear_logs();
        bus.en = 1'b1;
        wait_idle(600, "gap");
        check("gap trmt count", 32'(trmt_log.size()), 32'd2);
        if (trmt_cyc.size() >= 2 && done_cyc.size() >= 1)
            check("gap done-to-trmt", trmt_cyc[1] - done_cyc[0], 32'd102);

        // Loop mode replays 01,02,03; a push during a pop cycle is dropped.
        do_reset();
        bus.gap_cycles = '0;
        bus.en         = 1'b0;
        bus.loop_mode  = 1'b1;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        clear_logs();
        bus.en = 1'b1;
        wait_log(4, 200, "loop");
        wait_tx_done(50, "loop");
        @(negedge clk);
        bus.push      = 1'b1;
        bus.push_data = 8'hAA;
        @(negedge clk);
        bus.push = 1'b0;
        #1;
        check("loop concurrent push ovf", 32'(bus.ovf), 32'd1);
        check("loop fifo count", 32'(dut.u_fifo.count), 32'd3);
        check("loop empty", 32'(bus.empty), 32'd0);
        wait_log(7, 200, "loop replay");
        bus.en = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && !uart_busy) begin
                stopped = 1'b1;
                break;
            end
        end
        check("loop stop", 32'(stopped), 32'd1);
        for (int i = 0; i < 7; i++) begin
            if (i < trmt_log.size())
                check($sformatf("loop byte[%0d]", i), 32'(trmt_log[i]), 32'(exp_loop[i]));
        end
        bus.loop_mode = 1'b0;

        // Abort (pulsed twice) during WAIT_DONE with 5 bytes queued.
        do_reset();
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        clear_logs();
        bus.en = 1'b1;
        wait_log(1, 50, "abort wait");
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_idle(100, "abort wait");
        repeat (20) @(negedge clk);
        check("abort wait trmt count", 32'(trmt_log.size()), 32'd2);
        if (trmt_log.size() >= 2) begin
            check("abort wait first byte", 32'(trmt_log[0]), 32'hA0);
            check("abort wait stop byte", 32'(trmt_log[1]), 32'(CMD_STOP));
        end
        check("abort wait empty", 32'(bus.empty), 32'd1);
        check("abort wait sent_cnt", 32'(bus.sent_cnt), 32'd2);

        // Abort during GAP cuts the gap and issues the stop byte quickly.
        do_reset();
        bus.en         = 1'b0;
        bus.gap_cycles = 16'd50;
        push_byte(8'hB0);
        push_byte(8'hB1);
        clear_logs();
        bus.en = 1'b1;
        wait_tx_done(50, "abort gap");
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        ab_cyc    = cyc;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_idle(100, "abort gap");
        check("abort gap trmt count", 32'(trmt_log.size()), 32'd2);
        if (trmt_log.size() >= 2) begin
            lat = trmt_cyc[1] - ab_cyc;
            check("abort gap stop byte", 32'(trmt_log[1]), 32'(CMD_STOP));
            check("abort gap latency 1..3", 32'(lat >= 1 && lat <= 3), 32'd1);
        end
        check("abort gap empty", 32'(bus.empty), 32'd1);
        check("abort gap sent_cnt", 32'(bus.sent_cnt), 32'd2);

        // Reset in WAIT_DONE with an abort latched: no stop byte afterwards.
        do_reset();
        bus.gap_cycles = '0;
        bus.en         = 1'b1;
        clear_logs();
        push_byte(8'h55);
        wait_log(1, 50, "mid reset");
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid reset");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid reset trmt count", 32'(trmt_log.size()), 32'd1);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset sent_cnt", 32'(bus.sent_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
Synthesizable, parametrised command host that queues command bytes and streams them to an external UART transmitter with a programmable inter-command gap. It generalises the testbench cmd/send_cmd/cmd_sent handshake into a reusable block with a FIFO, a loop/replay mode and a priority abort that sends the stop command. It sits between a control source (scripted ROM, debug port or bench) and a UART_tx instance, and drives the Segway RX line indirectly.

Parameters:
DATA_W, 8, command byte width (must match the UART_tx data width)
DEPTH, 8, FIFO entries (power of 2, 2..64)
GAP_W, 16, width of the inter-command gap counter
CNT_W, 8, width of the sent-command counter
ABORT_CMD, 8'h73, byte sent on abort (ASCII 's', stop)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  allows dequeue and transmit when high
loop_mode  in  1  1 = each sent byte is recirculated to the FIFO tail
gap_cycles  in  GAP_W  idle clocks after tx_done before the next trmt
push  in  1  enqueue request
push_data  in  DATA_W  byte to enqueue
abort  in  1  single-cycle pulse: flush the queue and send ABORT_CMD
tx_done  in  1  completion pulse from UART_tx
trmt  out  1  one-cycle transmit strobe to UART_tx
tx_data  out  DATA_W  byte to UART_tx, held stable from trmt until tx_done
full  out  1  FIFO full
empty  out  1  FIFO empty
ovf  out  1  one-cycle pulse when a push is dropped
busy  out  1  FSM not in IDLE
sent_cnt  out  CNT_W  count of completed transmissions (wraps)

Behaviour:
- All state updates on posedge clk. Reset is applied when rst_n==0 at the edge.
- Reset values: trmt=0, tx_data=0, full=0, empty=1, ovf=0, busy=0, sent_cnt=0. FIFO pointers are cleared, the abort latch is cleared and the FSM goes to IDLE. Reset overrides any transfer in progress, with no abort byte.
- FIFO: circular buffer with a count of 0..DEPTH. Pointers wrap modulo DEPTH.
  - A push while full is dropped and ovf pulses.
  - Push and pop in the same cycle when not full: both happen and the count is unchanged.
- Loop recirculation: in loop_mode, the pop cycle writes the popped byte to the tail. If an external push lands in the same cycle, it is dropped and ovf pulses.
- Abort latch: set by abort, cleared when ABORT_CMD is issued. Multiple abort pulses collapse into one abort.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP, ABORT_ISSUE, ABORT_WAIT.
  - IDLE:
    - If the abort latch is set: flush the FIFO and go to ABORT_ISSUE.
    - Else if en && !empty: pop, register tx_data and go to ISSUE.
  - ISSUE: trmt=1 for exactly one cycle, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_done. The UART is never interrupted, so an abort here is only latched. On tx_done, sent_cnt increments, then:
    - abort latched: go to IDLE;
    - gap_cycles==0: go to IDLE;
    - otherwise load the counter with gap_cycles and go to GAP.
  - GAP: decrement each cycle and go to IDLE when the count reaches 1. An abort latched during GAP cuts the gap and goes to IDLE the next cycle.
  - ABORT_ISSUE: tx_data=ABORT_CMD and trmt for one cycle, then go to ABORT_WAIT.
  - ABORT_WAIT: on tx_done, increment sent_cnt, clear the latch and go to IDLE.
- gap_cycles is sampled only when the counter loads.
- Deasserting en stops new dequeues only. A byte already issued completes.
- Latency: a push at edge t into an empty FIFO with the FSM in IDLE and en=1 gives trmt high during cycle t+2.
- Minimum spacing: trmt to the next trmt is (UART time) + gap_cycles + 2 clocks.
- tx_done arriving outside WAIT_DONE/ABORT_WAIT is ignored.

Decomposition:
- Package uart_cmd_host_pkg holds:
  - the state enum type;
  - command constants CMD_GO=8'h67 and CMD_STOP=8'h73.
- One sub-module, cmd_fifo, parametrised by DATA_W and DEPTH. It provides push, pop, wdata, rdata, full, empty and count, with a synchronous active-low reset.
- The host FSM, the gap counter and the abort latch stay in the top.

Test Plan:
- Reset, then push 8'h67 with en=1 and gap_cycles=0 → trmt in the second cycle after the push, tx_data=8'h67; after tx_done, sent_cnt=1, busy=0, empty=1.
- Push 9 bytes back-to-back with DEPTH=8 and en=0 → full=1 after 8 pushes, ovf pulses once on the 9th, and only 8 bytes are sent after en=1.
- gap_cycles=100 with two bytes queued → exactly 102 clocks from the first tx_done to the second trmt.
- loop_mode=1 with 3 bytes {8'h01,8'h02,8'h03} → transmit order 01,02,03,01,02,03…; the count stays 3 and a concurrent push gives ovf.
- abort during WAIT_DONE with 5 bytes queued → the current byte completes, then 8'h73 is sent and empty=1 with no further trmt. abort during GAP → 8'h73 issued within 3 cycles.
- rst_n low mid WAIT_DONE → all outputs return to their reset values at the next edge, and no abort byte is sent.
